// File: rtl/srlatch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : srlatch_seq                                                      |
// | Purpose  : Round-robin set/clear sequencer for a bank of SR flag latches,   |
// |            with fixed-width s/r pulses, recovery gaps and a shadow copy.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module srlatch_seq #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3,
  parameter int PULSE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [NFLAG-1:0]     s_o,
  output logic [NFLAG-1:0]     r_o,
  output logic [NFLAG-1:0]     flags,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(PULSE + 1);

  localparam logic [PW-1:0]   c_LAST  = PW'(NREQ - 1);
  localparam logic [CW-1:0]   c_PULSE = CW'(PULSE);
  localparam logic [IDXW:0]   c_NFLAG = (IDXW + 1)'(NFLAG);
  localparam logic [NREQ-1:0] c_ONE   = NREQ'(1);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_GRANT = 3'd2;
  localparam logic [2:0] S_DRIVE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_win;
  logic             r_op;
  logic [IDXW-1:0]  r_idx;
  logic [NREQ-1:0]  r_excl;
  logic [NREQ-1:0]  r_ack;
  logic             r_err;
  logic [NFLAG-1:0] r_s;
  logic [NFLAG-1:0] r_r;
  logic [NFLAG-1:0] r_flags;
  logic             r_busy;

  logic [NREQ-1:0]  w_elig;
  logic [PW-1:0]    w_lo;
  logic [PW-1:0]    w_hi;
  logic             w_hit;
  logic [PW-1:0]    w_win;
  logic [IDXW-1:0]  w_win_idx;
  logic [NFLAG-1:0] w_sel;
  logic             w_oor;
  logic             w_cur;
  logic [NREQ-1:0]  w_win_oh;

  // The requester acked in the previous GAP still shows a stale req for one cycle.
  assign w_elig = req & ~r_excl;

  // Round-robin: lowest eligible index at or above the pointer, else lowest overall.
  always_comb begin
    w_lo  = '0;
    w_hi  = '0;
    w_hit = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_elig[j]) begin
        w_lo = PW'(j);
        if (PW'(j) >= r_ptr) begin
          w_hi  = PW'(j);
          w_hit = 1'b1;
        end
      end
    end
    w_win = w_hit ? w_hi : w_lo;
  end

  assign w_win_idx = idx[w_win*IDXW +: IDXW];

  always_comb begin
    w_sel = '0;
    for (int f = 0; f < NFLAG; f++) begin
      w_sel[f] = (r_idx == IDXW'(f));
    end
  end

  assign w_oor    = ({1'b0, r_idx} >= c_NFLAG);
  assign w_cur    = |(r_flags & w_sel);
  assign w_win_oh = c_ONE << r_win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_op    <= 1'b0;
      r_idx   <= '0;
      r_excl  <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_s     <= '0;
      r_r     <= '0;
      r_flags <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_busy <= 1'b1;
          if (r_cnt == c_PULSE) begin
            r_r     <= '0;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_r   <= '1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          r_excl <= '0;
          if (|w_elig) begin
            r_win   <= w_win;
            r_op    <= op[w_win];
            r_idx   <= w_win_idx;
            r_ptr   <= (w_win == c_LAST) ? '0 : w_win + PW'(1);
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_oor) begin
            r_err   <= 1'b1;
            r_ack   <= w_win_oh;
            r_state <= S_GAP;
          end else if (r_op == w_cur) begin
            r_ack   <= w_win_oh;
            r_state <= S_GAP;
          end else begin
            r_s     <= r_op ? w_sel : '0;
            r_r     <= r_op ? '0 : w_sel;
            r_cnt   <= CW'(1);
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_cnt == c_PULSE) begin
            r_s     <= '0;
            r_r     <= '0;
            r_flags <= r_op ? (r_flags | w_sel) : (r_flags & ~w_sel);
            r_ack   <= w_win_oh;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          r_excl  <= r_ack;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_s     <= '0;
          r_r     <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack   = r_ack;
  assign err   = r_err;
  assign s_o   = r_s;
  assign r_o   = r_r;
  assign flags = r_flags;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_srlatch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_srlatch_seq                                                   |
// | Purpose  : Scoreboard bench for srlatch_seq with a queue-based model.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_srlatch_seq;

  localparam int NREQ  = 4;
  localparam int NFLAG = 6;
  localparam int IDXW  = 3;
  localparam int PULSE = 2;
  localparam logic [NFLAG-1:0] ALL = '1;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      op;
  logic [NREQ*IDXW-1:0] idx;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic [NFLAG-1:0]     s_o;
  logic [NFLAG-1:0]     r_o;
  logic [NFLAG-1:0]     flags;
  logic                 busy;

  srlatch_seq #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW), .PULSE(PULSE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
    .ack(ack), .err(err), .s_o(s_o), .r_o(r_o), .flags(flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic             err;
    logic [NFLAG-1:0] s;
    logic [NFLAG-1:0] r;
    logic [NFLAG-1:0] flags;
    int               npulse;
  } exp_t;

  exp_t             sbq[$];
  logic [NFLAG-1:0] mflags;
  int               mptr;
  int               hold_left;
  int               n_pass;
  int               n_tot;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: apply one request to the shadow bank and queue the outcome.
  function automatic void serve(input int id);
    exp_t e;
    logic o;
    int   i;
    o = op[id];
    i = int'(idx[id*IDXW +: IDXW]);
    e.id = id; e.err = 1'b0; e.s = '0; e.r = '0; e.npulse = 0;
    if (i >= NFLAG) begin
      e.err = 1'b1;
    end else if (mflags[i] != o) begin
      if (o) e.s[i] = 1'b1;
      else   e.r[i] = 1'b1;
      e.npulse  = PULSE;
      mflags[i] = o;
    end
    e.flags = mflags;
    mptr    = (id + 1) % NREQ;
    sbq.push_back(e);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] pend);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (mptr + k) % NREQ;
      if (pend[c]) return c;
    end
    return 0;
  endfunction

  // Monitor: pin invariants every cycle, scoreboard pop on each ack.
  exp_t             mon_e;
  logic [NFLAG-1:0] mon_pins;
  int               acc_n;
  logic [NFLAG-1:0] acc_s;
  logic [NFLAG-1:0] acc_r;

  always @(negedge clk) begin
    chk("s_and_r", 64'(s_o & r_o), 64'(0));
    if (!rst_n) begin
      acc_n = 0; acc_s = '0; acc_r = '0;
    end else begin
      mon_pins = s_o | r_o;
      if (r_o != ALL) begin
        chk("pins_multi", 64'(mon_pins & (mon_pins - 1'b1)), 64'(0));
        if (mon_pins != '0) begin
          acc_n++; acc_s |= s_o; acc_r |= r_o;
        end
      end
      if (err && ack == '0) chk("err_alone", 64'(err), 64'(0));
      if (ack != '0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ack", 64'(ack), 64'(0));
        end else begin
          mon_e = sbq.pop_front();
          chk("ack_id", 64'(ack), 64'(1) << mon_e.id);
          chk("ack_err", 64'(err), 64'(mon_e.err));
          chk("flags", 64'(flags), 64'(mon_e.flags));
          chk("pulse", {32'(acc_n), 16'(acc_s), 16'(acc_r)},
                       {32'(mon_e.npulse), 16'(mon_e.s), 16'(mon_e.r)});
        end
        acc_n = 0; acc_s = '0; acc_r = '0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (ack != '0) begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) req = '0;
      end else begin
        req = req & ~ack;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin tick(); n++; end
    if (busy !== 1'b0) chk("wait_idle", 64'(busy), 64'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 400) begin tick(); n++; end
    if (sbq.size() > 0) chk("drain", 64'(sbq.size()), 64'(0));
  endtask

  task automatic check_init();
    for (int n = 0; n < PULSE; n++) begin
      tick();
      chk("init_r", 64'(r_o), 64'(ALL));
      chk("init_busy", 64'(busy), 64'(1));
    end
    tick();
    chk("init_gap_r", 64'(r_o), 64'(0));
    chk("init_gap_busy", 64'(busy), 64'(1));
    tick();
    chk("init_done_busy", 64'(busy), 64'(0));
    chk("init_flags", 64'(flags), 64'(0));
  endtask

  task automatic single(input int k, input logic o, input logic [IDXW-1:0] i,
                        input int exp_lat, input logic [2*NFLAG-1:0] exp_mid);
    int n, got;
    wait_idle();
    op[k] = o;
    idx[k*IDXW +: IDXW] = i;
    req[k] = 1'b1;
    serve(k);
    n = 0; got = -1;
    while (got < 0 && n < 40) begin
      tick(); n++;
      if (n == 1) chk("grant_busy", 64'(busy), 64'(1));
      if (n == 2) chk("pins_cycle2", 64'({s_o, r_o}), 64'(exp_mid));
      if (ack[k]) got = n;
    end
    chk("ack_latency", 64'(got), 64'(exp_lat));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] pend;
    int              id, t1, t2;
    n_pass = 0; n_tot = 0; hold_left = 0;
    acc_n = 0; acc_s = '0; acc_r = '0;
    mflags = '0; mptr = 0;
    rst_n = 1'b0; req = '0; op = '0; idx = '0;
    repeat (3) tick();
    chk("rst_outputs", 64'({ack, err, s_o, r_o, flags, busy}), 64'(0));
    rst_n = 1'b1;
    check_init();

    // All four request continuously; order follows the pointer from 0.
    wait_idle();
    op = '1;
    idx = {3'd4, 3'd2, 3'd1, 3'd0};
    hold_left = 5;
    req = '1;
    pend = '1;
    for (int t = 0; t < 5; t++) begin id = rr_pick(pend); serve(id); end
    drain();

    single(1, 1'b1, 3'd5, PULSE + 2, {6'b100000, 6'b000000});
    single(0, 1'b0, 3'd3, 2, '0);
    single(2, 1'b1, 3'd7, 2, '0);

    // A held req after ack must not be re-granted in the very next IDLE.
    wait_idle();
    op[3] = 1'b0;
    idx[3*IDXW +: IDXW] = 3'd1;
    hold_left = 2;
    req[3] = 1'b1;
    serve(3); serve(3);
    t1 = -1; t2 = -1;
    for (int n = 0; n < 60 && t2 < 0; n++) begin
      tick();
      if (ack[3]) begin
        if (t1 < 0) t1 = n;
        else t2 = n;
      end
    end
    chk("excl_gap", 64'(t2 - t1), 64'(4));

    for (int b = 0; b < 25; b++) begin
      wait_idle();
      pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int k = 0; k < NREQ; k++) begin
        op[k] = 1'($urandom_range(0, 1));
        idx[k*IDXW +: IDXW] = IDXW'($urandom_range(0, (1 << IDXW) - 1));
      end
      req = pend;
      while (pend != '0) begin id = rr_pick(pend); serve(id); pend[id] = 1'b0; end
      drain();
    end

    // Reset during the first DRIVE cycle: request is lost, bank re-inits.
    wait_idle();
    op[1] = ~mflags[2];
    idx[1*IDXW +: IDXW] = 3'd2;
    req[1] = 1'b1;
    t1 = 0;
    while ((s_o | r_o) == '0 && t1 < 20) begin tick(); t1++; end
    chk("drive_seen", 64'(((s_o | r_o) != '0)), 64'(1));
    rst_n = 1'b0;
    req = '0;
    tick();
    chk("rst_mid_pins", 64'({s_o, r_o}), 64'(0));
    chk("rst_mid_ack_busy", 64'({ack, busy}), 64'(0));
    chk("rst_mid_flags", 64'(flags), 64'(0));
    mflags = '0; mptr = 0;
    tick();
    rst_n = 1'b1;
    check_init();

    for (int b = 0; b < 4; b++) begin
      wait_idle();
      pend = '1;
      for (int k = 0; k < NREQ; k++) begin
        op[k] = 1'($urandom_range(0, 1));
        idx[k*IDXW +: IDXW] = IDXW'($urandom_range(0, (1 << IDXW) - 1));
      end
      req = pend;
      while (pend != '0) begin id = rr_pick(pend); serve(id); pend[id] = 1'b0; end
      drain();
    end

    repeat (4) tick();
    chk("queue_empty", 64'(sbq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
